seg_scan_ctrl: RTL and testbench
================================

// Module: seg_scan_ctrl
// PURPOSE
//   Parametrised N-digit multiplexed 7-segment controller; replaces the fixed 4-digit segdisplay/segclk pair.
//   Runs from the master clock with an internal prescaler, decodes hex nibbles and scans anodes.
//   Adds per-digit blanking and dp control, an anti-ghosting guard interval and tear-free frame snapshots.
//   Sits beside the VGA path in the top level; game logic drives the digits/dp/blank buses.
// PARAMETERS
//   NUM_DIGITS  4      digits scanned (1..16)
//   CLK_DIV     50000  clk cycles per digit slot (>= GUARD+2); 1 kHz slot rate at 50 MHz
//   GUARD       2      cycles at slot start with all anodes inactive (0 = no guard)
//   ACTIVE_LOW  1      1: seg/an/dp are active-low; 0: active-high
//   BLINK_DIV   250    full scans per blink half-period (used only with SEG_BLINK_EN)
// PORTS
//   clk        in   1              master clock, 50 MHz
//   clr        in   1              asynchronous reset, active-high
//   digits     in   4*NUM_DIGITS   hex nibble per digit; digit i = digits[4i+3:4i], digit 0 = rightmost
//   dp_in      in   NUM_DIGITS     decimal point request per digit
//   blank      in   NUM_DIGITS     1 = digit i kept dark
//   blink      in   NUM_DIGITS     1 = digit i blinks (ignored without SEG_BLINK_EN)
//   seg        out  7              segments {g,f,e,d,c,b,a}
//   dp         out  1              decimal point
//   an         out  NUM_DIGITS     anode enables, one-hot when active
//   scan_done  out  1              1-cycle pulse at end of every complete scan
// BEHAVIOUR
//   - Reset (async, clr=1): cnt=0, idx=0, primed=0, shadows=0; an/seg/dp all inactive
//     (ACTIVE_LOW=1: an='1, seg=7'h7F, dp=1); scan_done=0.
//   - Prescaler cnt counts 0..CLK_DIV-1, wraps; tick = (cnt==CLK_DIV-1).
//   - States: PRIME (primed=0) -> SCAN on first tick. Entering SCAN: idx=0, shadow<=digits/dp_in/blank.
//   - In SCAN, each tick: idx<=idx+1; if idx==NUM_DIGITS-1 then idx<=0, shadows reloaded, scan_done=1 next cycle.
//   - Inputs are sampled only at snapshot ticks; changes mid-scan never appear until the next scan.
//   - Slot output: an = one-hot(idx) when cnt>=GUARD and !shadow_blank[idx], else all inactive.
//     seg = hexdecode(shadow nibble idx); dp = shadow_dp[idx]. Outputs registered:
//     one-cycle latency from the cnt/idx value they reflect. In PRIME, all outputs are inactive.
//   - If an is inactive (guard or blank), seg and dp are also driven inactive.
//   - Hex decode (active-high gfedcba): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F
//     A=77 b=7C C=39 d=5E E=79 F=71; ACTIVE_LOW inverts seg, an and dp.
//   - Widths: cnt is $clog2(CLK_DIV) bits; idx is $clog2(NUM_DIGITS) bits (min 1); no overflow past terminal values.
//   - NUM_DIGITS=1: every tick is a scan end; scan_done pulses every CLK_DIV cycles.
//   - clr mid-scan: outputs inactive immediately (async); after release, PRIME restarts a full CLK_DIV wait.
// CONFIGURATION
//   SEG_BLINK_EN defined: bcnt counts scan_done pulses 0..BLINK_DIV-1; phase toggles on wrap;
//     phase resets to 0 (lit). When phase=1, digits with a blink bit latched at snapshot are dark, as if blanked.
//   SEG_BLINK_EN undefined: no blink counter/phase logic; blink port ignored; display identical to blink=0.
// TESTING (NUM_DIGITS=4, CLK_DIV=8, GUARD=2, ACTIVE_LOW=1)
//   1 clr=1 -> an=4'hF, seg=7'h7F, dp=1, scan_done=0 immediately; held until 8 cycles after release.
//   2 digits=16'h1234, dp_in=4'b0001 -> slot0: an=4'b1110 for 6 cycles, seg=7'h19 ("4"), dp=0; an=4'hF in the 2 guard cycles.
//   3 digits changed 16'h1234->16'hABCD during slot1 -> slots 1-3 still show 3,2,1; "D" appears after scan_done.
//   4 blank=4'b0100 -> an[2] never 0; slot2 outputs an=4'hF, seg=7'h7F for all 8 cycles.
//   5 clr pulsed mid slot2 -> outputs inactive same cycle; after release, PRIME and snapshot repeat; first digit is slot0.
//   6 SEG_BLINK_EN, BLINK_DIV=2, blink=4'b0010 -> digit1 lit scans 0-1, dark 2-3, lit 4-5; scan_done every 32 cycles.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seg_scan_ctrl
//   Parametrised N-digit multiplexed 7-segment display controller.
//   A prescaler divides the master clock into digit slots. After reset the
//   controller waits one full slot (PRIME), then scans the digits from
//   rightmost (0) to leftmost. Each slot begins with GUARD cycles with all
//   anodes off, which prevents ghosting between digits. The inputs
//   digits/dp_in/blank(/blink) are copied into shadow registers only at
//   scan boundaries, so a scan never mixes old and new values.
//
//   Optional feature macro: SEG_BLINK_EN
//     When defined, digits whose blink bit was latched at the snapshot go
//     dark during alternate groups of BLINK_DIV scans. When undefined, the
//     blink port is ignored.
//
// Ports
//   clk        in   master clock
//   clr        in   asynchronous reset, active-high
//   digits     in   hex nibble per digit, digit i = digits[4i+3:4i], digit 0 rightmost
//   dp_in      in   decimal point request per digit
//   blank      in   1 = digit kept dark
//   blink      in   1 = digit blinks (SEG_BLINK_EN only)
//   seg        out  segments {g,f,e,d,c,b,a}
//   dp         out  decimal point
//   an         out  anode enables, one-hot when active
//   scan_done  out  one-cycle pulse after each complete scan
// -----------------------------------------------------------------------------
module seg_scan_ctrl #(
   parameter int NUM_DIGITS = 4,
   parameter int CLK_DIV    = 50000,
   parameter int GUARD      = 2,
   parameter int ACTIVE_LOW = 1,
   parameter int BLINK_DIV  = 250
) (
   input  logic                    clk,
   input  logic                    clr,
   input  logic [4*NUM_DIGITS-1:0] digits,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic [NUM_DIGITS-1:0]   blank,
   input  logic [NUM_DIGITS-1:0]   blink,
   output logic [6:0]              seg,
   output logic                    dp,
   output logic [NUM_DIGITS-1:0]   an,
   output logic                    scan_done
);

   localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] GUARD_C = CNT_W'(GUARD);
   localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIGITS - 1);
   localparam logic             POL     = (ACTIVE_LOW != 0);
   localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{POL}};
   localparam logic [6:0]            SEG_OFF = {7{POL}};

   // Active-high gfedcba pattern for a hex nibble
   function automatic logic [6:0] hex7(input logic [3:0] n);
      case (n)
         4'h0: hex7 = 7'h3F;   4'h1: hex7 = 7'h06;
         4'h2: hex7 = 7'h5B;   4'h3: hex7 = 7'h4F;
         4'h4: hex7 = 7'h66;   4'h5: hex7 = 7'h6D;
         4'h6: hex7 = 7'h7D;   4'h7: hex7 = 7'h07;
         4'h8: hex7 = 7'h7F;   4'h9: hex7 = 7'h6F;
         4'hA: hex7 = 7'h77;   4'hB: hex7 = 7'h7C;
         4'hC: hex7 = 7'h39;   4'hD: hex7 = 7'h5E;
         4'hE: hex7 = 7'h79;   4'hF: hex7 = 7'h71;
         default: hex7 = 7'h00;
      endcase
   endfunction

   typedef enum logic {ST_PRIME = 1'b0, ST_SCAN = 1'b1} state_t;

   state_t                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [4*NUM_DIGITS-1:0] sh_dig_q, sh_dig_d;
   logic [NUM_DIGITS-1:0]   sh_dp_q, sh_dp_d;
   logic [NUM_DIGITS-1:0]   sh_blank_q, sh_blank_d;
   logic                    done_q, done_d;
   logic [NUM_DIGITS-1:0]   an_q, an_d;
   logic [6:0]              seg_q, seg_d;
   logic                    dp_q, dp_d;

   logic                    tick_s, load_s, scan_end_s, lit_s, blink_dark_s;
   logic [NUM_DIGITS-1:0]   onehot_s;
   logic [3:0]              nib_s;

   // Prescaler, scan sequencing and shadow snapshot
   always_comb begin
      tick_s     = (cnt_q == CNT_MAX);
      cnt_d      = tick_s ? '0 : cnt_q + CNT_W'(1);
      state_d    = state_q;
      idx_d      = idx_q;
      load_s     = 1'b0;
      scan_end_s = 1'b0;
      done_d     = 1'b0;
      case (state_q)
         ST_PRIME: begin
            if (tick_s) begin
               state_d = ST_SCAN;
               idx_d   = '0;
               load_s  = 1'b1;
            end else begin
               state_d = ST_PRIME;
            end
         end
         ST_SCAN: begin
            if (tick_s && (idx_q == IDX_MAX)) begin
               idx_d      = '0;
               load_s     = 1'b1;
               scan_end_s = 1'b1;
               done_d     = 1'b1;
            end else if (tick_s) begin
               idx_d = idx_q + IDX_W'(1);
            end else begin
               idx_d = idx_q;
            end
         end
         default: begin
            state_d = ST_PRIME;
            idx_d   = '0;
         end
      endcase
      sh_dig_d   = load_s ? digits : sh_dig_q;
      sh_dp_d    = load_s ? dp_in  : sh_dp_q;
      sh_blank_d = load_s ? blank  : sh_blank_q;
   end

`ifdef SEG_BLINK_EN
   localparam int BC_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [BC_W-1:0] BC_MAX = BC_W'(BLINK_DIV - 1);

   logic [BC_W-1:0]       bcnt_q, bcnt_d;
   logic                  phase_q, phase_d;
   logic [NUM_DIGITS-1:0] sh_blink_q, sh_blink_d;

   // Blink phase advances once every BLINK_DIV completed scans
   always_comb begin
      bcnt_d     = bcnt_q;
      phase_d    = phase_q;
      sh_blink_d = load_s ? blink : sh_blink_q;
      if (scan_end_s && (bcnt_q == BC_MAX)) begin
         bcnt_d  = '0;
         phase_d = ~phase_q;
      end else if (scan_end_s) begin
         bcnt_d = bcnt_q + BC_W'(1);
      end else begin
         bcnt_d = bcnt_q;
      end
      blink_dark_s = phase_q & sh_blink_q[idx_q];
   end

   // Blink state registers
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         bcnt_q     <= '0;
         phase_q    <= 1'b0;
         sh_blink_q <= '0;
      end else begin
         bcnt_q     <= bcnt_d;
         phase_q    <= phase_d;
         sh_blink_q <= sh_blink_d;
      end
   end
`else
   logic unused_blink;
   assign unused_blink = ^blink;
   assign blink_dark_s = 1'b0;
`endif

   // Slot output decode; an/seg/dp go dark together during guard or blanking
   always_comb begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
         onehot_s[i] = (idx_q == IDX_W'(i));
      end
      nib_s = sh_dig_q[{idx_q, 2'b00} +: 4];
      lit_s = (state_q == ST_SCAN) && (cnt_q >= GUARD_C) &&
              !sh_blank_q[idx_q] && !blink_dark_s;
      if (lit_s) begin
         an_d  = onehot_s ^ AN_OFF;
         seg_d = hex7(nib_s) ^ SEG_OFF;
         dp_d  = sh_dp_q[idx_q] ^ POL;
      end else begin
         an_d  = AN_OFF;
         seg_d = SEG_OFF;
         dp_d  = POL;
      end
   end

   // State and registered outputs
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q    <= ST_PRIME;
         cnt_q      <= '0;
         idx_q      <= '0;
         sh_dig_q   <= '0;
         sh_dp_q    <= '0;
         sh_blank_q <= '0;
         done_q     <= 1'b0;
         an_q       <= AN_OFF;
         seg_q      <= SEG_OFF;
         dp_q       <= POL;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         sh_dig_q   <= sh_dig_d;
         sh_dp_q    <= sh_dp_d;
         sh_blank_q <= sh_blank_d;
         done_q     <= done_d;
         an_q       <= an_d;
         seg_q      <= seg_d;
         dp_q       <= dp_d;
      end
   end

   assign an        = an_q;
   assign seg       = seg_q;
   assign dp        = dp_q;
   assign scan_done = done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_ctrl
//   Self-checking bench for seg_scan_ctrl with NUM_DIGITS=4, CLK_DIV=8,
//   GUARD=2, ACTIVE_LOW=1, BLINK_DIV=2. A timeline model derives the expected
//   outputs from the number of clock edges since reset release and pushes
//   them to a queue each rising edge; scenario tasks pop and compare on the
//   falling edge and add scenario-specific checks.
// -----------------------------------------------------------------------------
module tb_seg_scan_ctrl;

   localparam int ND   = 4;
   localparam int DIV  = 8;
   localparam int GRD  = 2;
   localparam int BDIV = 2;
   localparam int SCAN = ND * DIV;
   localparam logic [6:0] HEX_TAB [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   typedef struct packed {
      logic [3:0] an;
      logic [6:0] seg;
      logic       dp;
      logic       done;
   } exp_t;

   logic        clk = 1'b0;
   logic        clr = 1'b1;
   logic [15:0] digits = 16'h0000;
   logic [3:0]  dp_in = 4'h0;
   logic [3:0]  blank = 4'h0;
   logic [3:0]  blink = 4'h0;
   logic [6:0]  seg;
   logic        dp;
   logic [3:0]  an;
   logic        scan_done;

   int chk_cnt  = 0;
   int pass_cnt = 0;

   // model state
   int          m_cnt = 0;
   logic [15:0] sh_dig = 16'h0;
   logic [3:0]  sh_dp = 4'h0, sh_blank = 4'h0, sh_blink = 4'h0;
   logic        phase = 1'b0;
   int          bcnt = 0;
   exp_t        sb_q[$];

   seg_scan_ctrl #(.NUM_DIGITS(ND), .CLK_DIV(DIV), .GUARD(GRD), .ACTIVE_LOW(1), .BLINK_DIV(BDIV)) dut (
      .clk(clk), .clr(clr), .digits(digits), .dp_in(dp_in), .blank(blank), .blink(blink),
      .seg(seg), .dp(dp), .an(an), .scan_done(scan_done));

   always #5 clk = ~clk;

   // expected outputs visible after the next edge, from m_cnt edges since release
   function automatic exp_t model_exp();
      exp_t e;
      int   c, d;
      e = '{an: 4'hF, seg: 7'h7F, dp: 1'b1, done: 1'b0};
      if (m_cnt >= DIV) begin
         c = m_cnt % DIV;
         d = ((m_cnt - DIV) / DIV) % ND;
         if (c >= GRD && !sh_blank[d] && !(phase && sh_blink[d])) begin
            e.an  = ~(4'b0001 << d);
            e.seg = ~HEX_TAB[sh_dig[4*d +: 4]];
            e.dp  = ~sh_dp[d];
         end
         e.done = (c == DIV - 1) && (d == ND - 1);
      end
      return e;
   endfunction

   function automatic bit model_load();
      return (m_cnt % DIV == DIV - 1) && (m_cnt == DIV - 1 || ((m_cnt - DIV) / DIV) % ND == ND - 1);
   endfunction

   always @(posedge clk) begin
      if (clr) begin
         m_cnt <= 0; sh_dig <= '0; sh_dp <= '0; sh_blank <= '0; sh_blink <= '0;
         phase <= 1'b0; bcnt <= 0;
         sb_q.delete();
      end else begin
         sb_q.push_back(model_exp());
         if (model_load()) begin
            sh_dig <= digits; sh_dp <= dp_in; sh_blank <= blank; sh_blink <= blink;
`ifdef SEG_BLINK_EN
            if (m_cnt >= DIV) begin
               bcnt  <= (bcnt == BDIV - 1) ? 0 : bcnt + 1;
               phase <= (bcnt == BDIV - 1) ? ~phase : phase;
            end
`endif
         end
         m_cnt <= m_cnt + 1;
      end
   end

   task automatic test_reset();
      exp_t e;
      clr = 1'b1; digits = 16'h1234; dp_in = 4'b0001; blank = 4'h0; blink = 4'h0;
      repeat (3) @(negedge clk);
      chk_cnt++;
      if ({an, seg, dp, scan_done} !== {4'hF, 7'h7F, 1'b1, 1'b0})
         $display("FAIL reset_outputs: got %h required %h", {an, seg, dp, scan_done}, {4'hF, 7'h7F, 1'b1, 1'b0});
      else pass_cnt++;
      clr = 1'b0;
      for (int i = 0; i < DIV; i++) begin
         @(negedge clk);
         chk_cnt++;
         if (sb_q.size() == 0) $display("FAIL sb_empty_reset: got none required one entry");
         else begin
            e = sb_q.pop_front();
            if ({an, seg, dp, scan_done} !== e) $display("FAIL sb_reset: got %h required %h", {an, seg, dp, scan_done}, e);
            else pass_cnt++;
         end
         chk_cnt++;
         if (an !== 4'hF) $display("FAIL prime_an_dark: cycle %0d got %h required f", i, an);
         else pass_cnt++;
      end
   endtask

   task automatic test_scan();
      exp_t e;
      int c4 = 0, cg = 0, cd = 0;
      for (int i = 0; i < SCAN; i++) begin
         @(negedge clk);
         chk_cnt++;
         if (sb_q.size() == 0) $display("FAIL sb_empty_scan: got none required one entry");
         else begin
            e = sb_q.pop_front();
            if ({an, seg, dp, scan_done} !== e) $display("FAIL sb_scan: got %h required %h", {an, seg, dp, scan_done}, e);
            else pass_cnt++;
         end
         if (an == 4'b1110 && seg == 7'h19 && dp == 1'b0) c4++;
         if (i < DIV && an == 4'hF) cg++;
         if (scan_done) cd++;
      end
      chk_cnt++; if (c4 !== 6) $display("FAIL slot0_digit4: got %0d cycles required 6", c4); else pass_cnt++;
      chk_cnt++; if (cg !== 2) $display("FAIL slot0_guard: got %0d cycles required 2", cg); else pass_cnt++;
      chk_cnt++; if (cd !== 1) $display("FAIL scan_done_once: got %0d pulses required 1", cd); else pass_cnt++;
   endtask

   task automatic test_midscan_change();
      exp_t e;
      int bad = 0, c3 = 0, cdd = 0;
      for (int i = 0; i < SCAN + DIV; i++) begin
         @(negedge clk);
         chk_cnt++;
         if (sb_q.size() == 0) $display("FAIL sb_empty_mid: got none required one entry");
         else begin
            e = sb_q.pop_front();
            if ({an, seg, dp, scan_done} !== e) $display("FAIL sb_mid: got %h required %h", {an, seg, dp, scan_done}, e);
            else pass_cnt++;
         end
         if (i == 9) digits = 16'hABCD;
         if (i >= 10 && i < SCAN) begin
            if (an != 4'hF && !(seg inside {7'h30, 7'h24, 7'h79})) bad++;
            if (an == 4'b1101 && seg == 7'h30) c3++;
         end
         if (i >= SCAN && an == 4'b1110 && seg == 7'h21) cdd++;
      end
      chk_cnt++; if (bad !== 0) $display("FAIL mid_no_new_digits: got %0d cycles required 0", bad); else pass_cnt++;
      chk_cnt++; if (c3 !== 6) $display("FAIL mid_slot1_old3: got %0d cycles required 6", c3); else pass_cnt++;
      chk_cnt++; if (cdd !== 6) $display("FAIL next_scan_D: got %0d cycles required 6", cdd); else pass_cnt++;
   endtask

   task automatic test_blank();
      exp_t e;
      int a2 = 0, cdark = 0, n = 0;
      blank = 4'b0100;
      while (!(m_cnt % SCAN == DIV && n > 0) && n < 3 * SCAN) begin
         @(negedge clk);
         n++;
         chk_cnt++;
         if (sb_q.size() == 0) $display("FAIL sb_empty_blank_wait: got none required one entry");
         else begin
            e = sb_q.pop_front();
            if ({an, seg, dp, scan_done} !== e) $display("FAIL sb_blank_wait: got %h required %h", {an, seg, dp, scan_done}, e);
            else pass_cnt++;
         end
      end
      chk_cnt++; if (n >= 3 * SCAN) $display("FAIL blank_align_timeout: got %0d cycles required < %0d", n, 3 * SCAN); else pass_cnt++;
      for (int i = 0; i < SCAN; i++) begin
         @(negedge clk);
         chk_cnt++;
         if (sb_q.size() == 0) $display("FAIL sb_empty_blank: got none required one entry");
         else begin
            e = sb_q.pop_front();
            if ({an, seg, dp, scan_done} !== e) $display("FAIL sb_blank: got %h required %h", {an, seg, dp, scan_done}, e);
            else pass_cnt++;
         end
         if (an[2] == 1'b0) a2++;
         if (an == 4'hF && seg == 7'h7F) cdark++;
      end
      chk_cnt++; if (a2 !== 0) $display("FAIL blank_an2_lit: got %0d cycles required 0", a2); else pass_cnt++;
      chk_cnt++; if (cdark !== 14) $display("FAIL blank_dark_cycles: got %0d required 14", cdark); else pass_cnt++;
   endtask

   task automatic test_clr_midscan();
      exp_t e;
      int n = 0, c0 = 0, other = 0;
      blank = 4'h0;
      while (!(m_cnt % SCAN == DIV + 2 * DIV + 4 && n > SCAN) && n < 3 * SCAN) begin
         @(negedge clk);
         n++;
         chk_cnt++;
         if (sb_q.size() == 0) $display("FAIL sb_empty_clr_wait: got none required one entry");
         else begin
            e = sb_q.pop_front();
            if ({an, seg, dp, scan_done} !== e) $display("FAIL sb_clr_wait: got %h required %h", {an, seg, dp, scan_done}, e);
            else pass_cnt++;
         end
      end
      chk_cnt++; if (an !== 4'b1011) $display("FAIL pre_clr_slot2: got %h required b", an); else pass_cnt++;
      clr = 1'b1;
      #1;
      chk_cnt++;
      if ({an, seg, dp, scan_done} !== {4'hF, 7'h7F, 1'b1, 1'b0})
         $display("FAIL clr_async_dark: got %h required %h", {an, seg, dp, scan_done}, {4'hF, 7'h7F, 1'b1, 1'b0});
      else pass_cnt++;
      @(posedge clk);
      @(negedge clk);
      clr = 1'b0;
      for (int i = 0; i < 2 * DIV; i++) begin
         @(negedge clk);
         chk_cnt++;
         if (sb_q.size() == 0) $display("FAIL sb_empty_clr: got none required one entry");
         else begin
            e = sb_q.pop_front();
            if ({an, seg, dp, scan_done} !== e) $display("FAIL sb_clr: got %h required %h", {an, seg, dp, scan_done}, e);
            else pass_cnt++;
         end
         if (i < DIV) begin
            chk_cnt++;
            if (an !== 4'hF) $display("FAIL clr_prime_dark: cycle %0d got %h required f", i, an);
            else pass_cnt++;
         end else if (an == 4'b1110) c0++;
         else if (an != 4'hF) other++;
      end
      chk_cnt++; if (c0 !== 6) $display("FAIL clr_first_slot0: got %0d cycles required 6", c0); else pass_cnt++;
      chk_cnt++; if (other !== 0) $display("FAIL clr_other_slot: got %0d cycles required 0", other); else pass_cnt++;
   endtask

`ifdef SEG_BLINK_EN
   task automatic test_blink();
      exp_t e;
      int lit1, cd, last_done;
      clr = 1'b1; digits = 16'h0000; dp_in = 4'h0; blank = 4'h0; blink = 4'b0010;
      repeat (2) @(negedge clk);
      clr = 1'b0;
      for (int s = -1; s < 6; s++) begin
         lit1 = 0; cd = 0; last_done = 0;
         for (int i = 0; i < ((s < 0) ? DIV : SCAN); i++) begin
            @(negedge clk);
            chk_cnt++;
            if (sb_q.size() == 0) $display("FAIL sb_empty_blink: got none required one entry");
            else begin
               e = sb_q.pop_front();
               if ({an, seg, dp, scan_done} !== e) $display("FAIL sb_blink: got %h required %h", {an, seg, dp, scan_done}, e);
               else pass_cnt++;
            end
            if (an == 4'b1101) lit1++;
            if (scan_done) begin cd++; last_done = (i == SCAN - 1); end
         end
         if (s >= 0) begin
            chk_cnt++;
            if ((lit1 != 0) !== (s != 2 && s != 3)) $display("FAIL blink_scan%0d: got %0d lit cycles required %0d", s, lit1, (s == 2 || s == 3) ? 0 : 6);
            else pass_cnt++;
            chk_cnt++;
            if (cd !== 1 || last_done !== 1) $display("FAIL blink_done%0d: got %0d pulses (at end %0d) required 1 at end", s, cd, last_done);
            else pass_cnt++;
         end
      end
   endtask
`endif

   initial begin
      test_reset();
      test_scan();
      test_midscan_change();
      test_blank();
      test_clr_midscan();
`ifdef SEG_BLINK_EN
      test_blink();
`endif
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
